// File: rtl/neuron_seq.sv
// Sequences one shared neuron pipeline across NUM_NEU logical neurons per layer pass.
// Optional argmax tracker enabled by defining NEURON_SEQ_ARGMAX_EN.
module neuron_seq #(
    parameter int DATA_W  = 32,
    parameter int NUM_NEU = 10,
    parameter int IDX_W   = 4,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_neu_reset,
    output logic              o_neu_in_rdy,
    output logic [IDX_W-1:0]  o_neu_sel,
    input  logic [DATA_W-1:0] i_neu_out,
    input  logic              i_neu_rdy,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [IDX_W-1:0]  o_best_idx,
    output logic [DATA_W-1:0] o_best_val
);

    localparam int CMAX  = (CLR_CYC > TIMEOUT) ? CLR_CYC : TIMEOUT;
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_CAPT, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_err;
    logic [DATA_W-1:0]   r_capt;
    logic [DATA_W-1:0]   r_res [NUM_NEU];
    logic                w_tmo;
    logic                w_last;
    logic                w_accept;

    assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_last   = (r_idx == IDX_W'(NUM_NEU - 1));
    assign w_accept = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (i_start) w_next = S_CLR;
            S_CLR:  if (r_cnt == CNT_W'(CLR_CYC - 1)) w_next = S_RUN;
            S_RUN:  if (i_neu_rdy || w_tmo) w_next = S_CAPT;
            S_CAPT: w_next = w_last ? S_DONE : S_CLR;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_neu_reset  = 1'b0;
        o_neu_in_rdy = 1'b0;
        unique case (r_state)
            S_CLR:  o_busy = 1'b1;
            S_RUN, S_CAPT: begin
                o_busy       = 1'b1;
                o_neu_reset  = 1'b1;
                o_neu_in_rdy = 1'b1;
            end
            S_DONE: o_done = 1'b1;
            default: ;
        endcase
        o_neu_sel = o_busy ? r_idx : '0;
        o_err     = r_err;
    end

    // Capture value is latched on RUN exit so the CAPT write does not depend on neu_out holding.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
            r_capt <= '0;
            for (int i = 0; i < NUM_NEU; i++) r_res[i] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (i_start) begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    r_err <= 1'b0;
                end
                S_CLR: begin
                    if (w_next == S_RUN) r_cnt <= '0;
                    else                 r_cnt <= r_cnt + 1'b1;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_neu_rdy) begin
                        r_capt <= i_neu_out;
                    end else if (w_tmo) begin
                        r_capt <= '0;
                        r_err  <= 1'b1;
                    end
                end
                S_CAPT: begin
                    r_cnt <= '0;
                    for (int i = 0; i < NUM_NEU; i++)
                        if (r_idx == IDX_W'(i)) r_res[i] <= r_capt;
                    if (!w_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_NEU; i++)
            if (i_rd_idx == IDX_W'(i)) o_rd_data = r_res[i];
    end

`ifdef NEURON_SEQ_ARGMAX_EN
    logic [IDX_W-1:0]  r_best_idx;
    logic [DATA_W-1:0] r_best_val;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept) begin
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (r_state == S_CAPT &&
                     (r_idx == '0 || $signed(r_capt) > $signed(r_best_val))) begin
            r_best_idx <= r_idx;
            r_best_val <= r_capt;
        end
    end

    assign o_best_idx = r_best_idx;
    assign o_best_val = r_best_val;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign o_best_idx = '0;
    assign o_best_val = '0;
`endif

endmodule
